// File: rtl/mips_pkg.sv
// Shared opcode, funct, ALUOp and ALU-control encodings for the MIPS execute stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_alu_core.sv
// Pure combinational ALU: and/or/add/sub/signed-slt/nor with a zero flag.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         zero
);

  logic slt_bit;

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    out = '0;
    unique case (ctl)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_SLT: out = {{(W-1){1'b0}}, slt_bit};
      ALU_NOR: out = ~(a | b);
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/mips_exec_ctrl.sv
// Main decode, ALU control and ALU for the MIPS execute stage, with the
// EX->MEM pipeline register for the ALU result and downstream controls.
module mips_exec_ctrl
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         bubble,
  output logic         regdst,
  output logic         alusrc,
  output logic         branch,
  output logic         memread,
  output logic         memwrite,
  output logic         memtoreg,
  output logic         regwrite,
  output logic [1:0]   aluop,
  output logic [3:0]   aluctl,
  output logic [W-1:0] alu_out,
  output logic         zero,
  output logic [W-1:0] result_q,
  output logic         zero_q,
  output logic         regwrite_q,
  output logic         memtoreg_q,
  output logic         memread_q,
  output logic         memwrite_q
);

  logic [W-1:0] result_d;
  logic         zero_d;
  logic         regwrite_d;
  logic         memtoreg_d;
  logic         memread_d;
  logic         memwrite_d;

  always_comb begin
    regdst   = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    aluop    = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        alusrc   = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        memread  = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = ALUOP_SUB;
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    aluctl = ALU_AND;
    unique case (aluop)
      ALUOP_ADD: aluctl = ALU_ADD;
      ALUOP_SUB: aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_SLT:  aluctl = ALU_SLT;
          FN_NOR:  aluctl = ALU_NOR;
          default: aluctl = ALU_AND;
        endcase
      end
      ALUOP_NONE: aluctl = ALU_AND;
      default:    aluctl = ALU_AND;
    endcase
  end

  mips_alu_core #(.W(W)) u_alu (
    .ctl  (aluctl),
    .a    (op_a),
    .b    (op_b),
    .out  (alu_out),
    .zero (zero)
  );

  // A bubble squashes only the side-effecting controls; the ALU result still flows.
  always_comb begin
    result_d   = alu_out;
    zero_d     = zero;
    regwrite_d = regwrite & ~bubble;
    memtoreg_d = memtoreg & ~bubble;
    memread_d  = memread  & ~bubble;
    memwrite_d = memwrite & ~bubble;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: decode, ALU control, ALU edges, pipeline register, bubble, reset.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [31:0] op_a, op_b;
  logic        bubble;
  logic        regdst, alusrc, branch, memread, memwrite, memtoreg, regwrite;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] alu_out, result_q;
  logic        zero, zero_q, regwrite_q, memtoreg_q, memread_q, memwrite_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] ctrl;  // {regdst,alusrc,branch,memread,memwrite,memtoreg,regwrite,aluop}
  logic [3:0] ctrl_q; // {regwrite_q,memtoreg_q,memread_q,memwrite_q}
  assign ctrl   = {regdst, alusrc, branch, memread, memwrite, memtoreg, regwrite, aluop};
  assign ctrl_q = {regwrite_q, memtoreg_q, memread_q, memwrite_q};

  mips_exec_ctrl #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .op_a(op_a), .op_b(op_b), .bubble(bubble),
    .regdst(regdst), .alusrc(alusrc), .branch(branch), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
    .aluop(aluop), .aluctl(aluctl), .alu_out(alu_out), .zero(zero),
    .result_q(result_q), .zero_q(zero_q), .regwrite_q(regwrite_q),
    .memtoreg_q(memtoreg_q), .memread_q(memread_q), .memwrite_q(memwrite_q)
  );

  always #5 clk = ~clk;

  logic [5:0]  sw_fn  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0]  sw_ctl [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  logic [31:0] sw_res [6] = '{32'h16, 32'h2, 32'h8, 32'hE, 32'hFFFFFFF1, 32'h0};

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic bub);
    opcode = op; funct = fn; op_a = a; op_b = b; bubble = bub;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(6'h00, 6'h20, 32'hC, 32'hA, 1'b0);
    tick();
    n_cmp++;
    if (result_q !== 32'h16 || ctrl_q !== 4'b1000) begin
      n_err++; $display("FAIL reset_pre: result_q=%h ctrl_q=%b want 00000016 1000", result_q, ctrl_q);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (result_q !== 32'h0 || zero_q !== 1'b0 || ctrl_q !== 4'b0000) begin
      n_err++; $display("FAIL reset_async: result_q=%h zero_q=%b ctrl_q=%b want 0 0 0000", result_q, zero_q, ctrl_q);
    end
    n_cmp++;
    if (alu_out !== 32'h16 || ctrl !== 9'b1_0_0_0_0_0_1_10) begin
      n_err++; $display("FAIL reset_comb: alu_out=%h ctrl=%b want 00000016 100000110", alu_out, ctrl);
    end
    tick();
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (result_q !== 32'h0 || ctrl_q !== 4'b0000) begin
      n_err++; $display("FAIL reset_hold: result_q=%h ctrl_q=%b want 0 0000", result_q, ctrl_q);
    end
    tick();
    n_cmp++;
    if (result_q !== 32'h16 || ctrl_q !== 4'b1000) begin
      n_err++; $display("FAIL reset_release: result_q=%h ctrl_q=%b want 00000016 1000", result_q, ctrl_q);
    end
  endtask

  task automatic test_rtype_sweep();
    for (int i = 0; i < 6; i++) begin
      drive(6'h00, sw_fn[i], 32'hC, 32'hA, 1'b0);
      n_cmp++;
      if (ctrl !== 9'b1_0_0_0_0_0_1_10 || aluctl !== sw_ctl[i]) begin
        n_err++; $display("FAIL rtype_dec[%0d]: ctrl=%b aluctl=%b want 100000110 %b", i, ctrl, aluctl, sw_ctl[i]);
      end
      n_cmp++;
      if (alu_out !== sw_res[i] || zero !== (sw_res[i] == 32'h0)) begin
        n_err++; $display("FAIL rtype_alu[%0d]: alu_out=%h zero=%b want %h", i, alu_out, zero, sw_res[i]);
      end
      tick();
      n_cmp++;
      if (result_q !== sw_res[i] || regwrite_q !== 1'b1) begin
        n_err++; $display("FAIL rtype_q[%0d]: result_q=%h regwrite_q=%b want %h 1", i, result_q, regwrite_q, sw_res[i]);
      end
    end
  endtask

  task automatic test_lw_sw();
    drive(6'h23, 6'h00, 32'h100, 32'h10, 1'b0);
    n_cmp++;
    if (ctrl !== 9'b0_1_0_1_0_1_1_00 || aluctl !== 4'b0010 || alu_out !== 32'h110) begin
      n_err++; $display("FAIL lw_comb: ctrl=%b aluctl=%b alu_out=%h want 010101100 0010 00000110", ctrl, aluctl, alu_out);
    end
    tick();
    drive(6'h2B, 6'h00, 32'h200, 32'h4, 1'b0);
    n_cmp++;
    if (ctrl_q !== 4'b1110 || result_q !== 32'h110) begin
      n_err++; $display("FAIL lw_q: ctrl_q=%b result_q=%h want 1110 00000110", ctrl_q, result_q);
    end
    n_cmp++;
    if (ctrl !== 9'b0_1_0_0_1_0_0_00 || alu_out !== 32'h204) begin
      n_err++; $display("FAIL sw_comb: ctrl=%b alu_out=%h want 010010000 00000204", ctrl, alu_out);
    end
    tick();
    n_cmp++;
    if (ctrl_q !== 4'b0001 || result_q !== 32'h204) begin
      n_err++; $display("FAIL sw_q: ctrl_q=%b result_q=%h want 0001 00000204", ctrl_q, result_q);
    end
  endtask

  task automatic test_beq();
    drive(6'h04, 6'h00, 32'd5, 32'd5, 1'b0);
    n_cmp++;
    if (ctrl !== 9'b0_0_1_0_0_0_0_01 || aluctl !== 4'b0110 || alu_out !== 32'h0 || zero !== 1'b1) begin
      n_err++; $display("FAIL beq_eq: ctrl=%b aluctl=%b alu_out=%h zero=%b want 001000001 0110 0 1", ctrl, aluctl, alu_out, zero);
    end
    tick();
    n_cmp++;
    if (zero_q !== 1'b1 || ctrl_q !== 4'b0000) begin
      n_err++; $display("FAIL beq_q: zero_q=%b ctrl_q=%b want 1 0000", zero_q, ctrl_q);
    end
    drive(6'h04, 6'h00, 32'd5, 32'd6, 1'b0);
    n_cmp++;
    if (zero !== 1'b0 || alu_out !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL beq_ne: zero=%b alu_out=%h want 0 ffffffff", zero, alu_out);
    end
  endtask

  task automatic test_edges();
    drive(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 1'b0);
    n_cmp++;
    if (alu_out !== 32'h1) begin
      n_err++; $display("FAIL slt_neg: alu_out=%h want 00000001", alu_out);
    end
    drive(6'h00, 6'h2A, 32'h80000000, 32'h1, 1'b0);
    n_cmp++;
    if (alu_out !== 32'h1) begin
      n_err++; $display("FAIL slt_min: alu_out=%h want 00000001", alu_out);
    end
    drive(6'h00, 6'h2A, 32'h1, 32'h80000000, 1'b0);
    n_cmp++;
    if (alu_out !== 32'h0 || zero !== 1'b1) begin
      n_err++; $display("FAIL slt_rev: alu_out=%h zero=%b want 0 1", alu_out, zero);
    end
    drive(6'h00, 6'h2A, 32'h1234, 32'h1234, 1'b0);
    n_cmp++;
    if (alu_out !== 32'h0) begin
      n_err++; $display("FAIL slt_eq: alu_out=%h want 0", alu_out);
    end
    drive(6'h08, 6'h00, 32'h7FFFFFFF, 32'h1, 1'b0);
    n_cmp++;
    if (alu_out !== 32'h80000000 || zero !== 1'b0 || ctrl !== 9'b0_1_0_0_0_0_1_00) begin
      n_err++; $display("FAIL add_ovf: alu_out=%h zero=%b ctrl=%b want 80000000 0 010000100", alu_out, zero, ctrl);
    end
    drive(6'h00, 6'h22, 32'h0, 32'h1, 1'b0);
    n_cmp++;
    if (alu_out !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL sub_wrap: alu_out=%h want ffffffff", alu_out);
    end
    drive(6'h00, 6'h3F, 32'hF0F0, 32'hFF00, 1'b0);
    n_cmp++;
    if (aluctl !== 4'b0000 || alu_out !== 32'hF000) begin
      n_err++; $display("FAIL bad_funct: aluctl=%b alu_out=%h want 0000 0000f000", aluctl, alu_out);
    end
    drive(6'h3F, 6'h22, 32'h3, 32'h4, 1'b0);
    n_cmp++;
    if (ctrl !== 9'b0 || aluctl !== 4'b0010 || alu_out !== 32'h7) begin
      n_err++; $display("FAIL bad_opcode: ctrl=%b aluctl=%b alu_out=%h want 0 0010 7", ctrl, aluctl, alu_out);
    end
  endtask

  task automatic test_bubble();
    drive(6'h23, 6'h00, 32'h100, 32'h10, 1'b1);
    n_cmp++;
    if (ctrl !== 9'b0_1_0_1_0_1_1_00) begin
      n_err++; $display("FAIL bubble_comb: ctrl=%b want 010101100", ctrl);
    end
    tick();
    n_cmp++;
    if (ctrl_q !== 4'b0000 || result_q !== 32'h110 || zero_q !== 1'b0) begin
      n_err++; $display("FAIL bubble_q: ctrl_q=%b result_q=%h zero_q=%b want 0000 00000110 0", ctrl_q, result_q, zero_q);
    end
  endtask

  task automatic test_back_to_back();
    drive(6'h23, 6'h00, 32'h40, 32'h8, 1'b0);
    tick();
    n_cmp++;
    if (ctrl_q !== 4'b1110 || result_q !== 32'h48) begin
      n_err++; $display("FAIL b2b_lw: ctrl_q=%b result_q=%h want 1110 00000048", ctrl_q, result_q);
    end
    drive(6'h00, 6'h27, 32'h0, 32'h0, 1'b1);
    tick();
    n_cmp++;
    if (ctrl_q !== 4'b0000 || result_q !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL b2b_bub: ctrl_q=%b result_q=%h want 0000 ffffffff", ctrl_q, result_q);
    end
    drive(6'h00, 6'h27, 32'hFFFFFFFF, 32'h0, 1'b0);
    tick();
    n_cmp++;
    if (ctrl_q !== 4'b1000 || result_q !== 32'h0 || zero_q !== 1'b1) begin
      n_err++; $display("FAIL b2b_nor: ctrl_q=%b result_q=%h zero_q=%b want 1000 0 1", ctrl_q, result_q, zero_q);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'h00, 6'h00, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    test_reset();
    test_rtype_sweep();
    test_lw_sw();
    test_beq();
    test_edges();
    test_bubble();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
